// File: rtl/branch_resolver.sv
// branch_resolver: resolves BEQ/BNE outcomes in execute, checks them against the
// fetch-time prediction and, on a mispredict, issues a registered PC redirect plus a
// FLUSH_CYC-cycle pipeline flush. A 2-bit saturating BHT supplies fetch predictions.
//
// Ports:
//   CLK, RST_N                    clock, asynchronous active-low reset
//   F_VALID, F_PC, PRED_TAKEN     fetch lookup (PRED_TAKEN is combinational)
//   EX_VALID, EX_BR, EX_FUNCT3,   execute-stage branch: type, PC, PC+imm target,
//   EX_PC, EX_TARGET, EX_PRED     and the prediction it was fetched with
//   BrRes                         comparator result, 1 = operands differ
//   EX_READY                      resolver idle and able to accept a branch
//   REDIRECT, REDIRECT_PC         one-cycle redirect pulse and corrected fetch address
//   FLUSH                         squash wrong-path instructions
//   MISPRED_CNT                   saturating mispredict counter
module branch_resolver #(
    parameter int IDX_W     = 4,
    parameter int FLUSH_CYC = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        F_VALID,
    input  logic [31:0] F_PC,
    output logic        PRED_TAKEN,
    input  logic        EX_VALID,
    input  logic        EX_BR,
    input  logic [2:0]  EX_FUNCT3,
    input  logic [31:0] EX_PC,
    input  logic [31:0] EX_TARGET,
    input  logic        EX_PRED,
    input  logic        BrRes,
    output logic        EX_READY,
    output logic        REDIRECT,
    output logic [31:0] REDIRECT_PC,
    output logic        FLUSH,
    output logic [15:0] MISPRED_CNT
);

    localparam int         ENTRIES    = 1 << IDX_W;
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYC);

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_FLUSHING = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [1:0]       bht_q [ENTRIES];
    logic             redirect_q;
    logic [31:0]      redirect_pc_q;
    logic [15:0]      mispred_cnt_q, mispred_cnt_d;

    logic             is_beq, is_bne, accept, taken, mispred;
    logic [IDX_W-1:0] ex_idx, f_idx;
    logic [1:0]       bht_cur, bht_next;
    logic [31:0]      correct_pc;

    // Only the index bits of the fetch PC are needed for the lookup.
    logic unused_fpc;
    assign unused_fpc = ^{F_PC[31:IDX_W+2], F_PC[1:0]};

    assign is_beq  = (EX_FUNCT3 == 3'b000);
    assign is_bne  = (EX_FUNCT3 == 3'b001);
    assign accept  = EX_VALID & EX_BR & EX_READY & (is_beq | is_bne);
    assign taken   = is_bne ? BrRes : ~BrRes;
    assign mispred = accept & (taken != EX_PRED);

    assign ex_idx  = EX_PC[IDX_W+1:2];
    assign f_idx   = F_PC[IDX_W+1:2];
    assign bht_cur = bht_q[ex_idx];

    always_comb begin
        bht_next = bht_cur;
        if (taken) begin
            if (bht_cur != 2'b11) bht_next = bht_cur + 2'b01;
        end else begin
            if (bht_cur != 2'b00) bht_next = bht_cur - 2'b01;
        end
    end

    // PC+4 wraps naturally in 32 bits.
    assign correct_pc = taken ? EX_TARGET : (EX_PC + 32'd4);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_IDLE) begin
            if (mispred) begin
                state_d = ST_FLUSHING;
                cnt_d   = FLUSH_LOAD;
            end
        end else begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_d == 4'd0) state_d = ST_IDLE;
        end
    end

    always_comb begin
        mispred_cnt_d = mispred_cnt_q;
        if (mispred && (mispred_cnt_q != 16'hFFFF)) mispred_cnt_d = mispred_cnt_q + 16'd1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 4'd0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'h0000_0000;
            mispred_cnt_q <= 16'h0000;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            redirect_q    <= mispred;
            mispred_cnt_q <= mispred_cnt_d;
            if (mispred) redirect_pc_q <= correct_pc;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < ENTRIES; i++) bht_q[i] <= 2'b01;
        end else if (accept) begin
            bht_q[ex_idx] <= bht_next;
        end
    end

    // Lookup reads the registered table, so a same-cycle update is seen next cycle.
    assign PRED_TAKEN  = F_VALID & bht_q[f_idx][1];
    assign EX_READY    = (state_q == ST_IDLE);
    assign FLUSH       = (state_q == ST_FLUSHING);
    assign REDIRECT    = redirect_q;
    assign REDIRECT_PC = redirect_pc_q;
    assign MISPRED_CNT = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
module tb_branch_resolver;

    logic        CLK, RST_N;
    logic        F_VALID;
    logic [31:0] F_PC;
    logic        PRED_TAKEN;
    logic        EX_VALID, EX_BR, EX_PRED, BrRes;
    logic [2:0]  EX_FUNCT3;
    logic [31:0] EX_PC, EX_TARGET;
    logic        EX_READY, REDIRECT, FLUSH;
    logic [31:0] REDIRECT_PC;
    logic [15:0] MISPRED_CNT;

    branch_resolver #(.IDX_W(4), .FLUSH_CYC(2)) dut (
        .CLK(CLK), .RST_N(RST_N), .F_VALID(F_VALID), .F_PC(F_PC), .PRED_TAKEN(PRED_TAKEN),
        .EX_VALID(EX_VALID), .EX_BR(EX_BR), .EX_FUNCT3(EX_FUNCT3), .EX_PC(EX_PC),
        .EX_TARGET(EX_TARGET), .EX_PRED(EX_PRED), .BrRes(BrRes), .EX_READY(EX_READY),
        .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC), .FLUSH(FLUSH),
        .MISPRED_CNT(MISPRED_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] cnt;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_pred(input string name, input logic [31:0] pc, input logic req);
        F_VALID = 1'b1;
        F_PC    = pc;
        #1;
        check(name, {31'b0, PRED_TAKEN}, {31'b0, req});
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_br(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                          input logic pred, input logic res);
        EX_VALID  = 1'b1;
        EX_BR     = 1'b1;
        EX_FUNCT3 = f3;
        EX_PC     = pc;
        EX_TARGET = tgt;
        EX_PRED   = pred;
        BrRes     = res;
    endtask

    task automatic idle_ex();
        EX_VALID = 1'b0;
        EX_BR    = 1'b0;
    endtask

    // Monitor: every redirect pulse must match the oldest expected mispredict.
    always @(negedge CLK) begin
        if (RST_N && REDIRECT) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_redirect: got pc 0x%08h, expected no redirect",
                         REDIRECT_PC);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("redirect_pc", REDIRECT_PC, e.pc);
                check("mispred_cnt_at_redirect", {16'h0, MISPRED_CNT}, {16'h0, e.cnt});
            end
        end
    end

    initial begin
        RST_N = 1'b0; F_VALID = 1'b0; F_PC = '0;
        EX_VALID = 1'b0; EX_BR = 1'b0; EX_FUNCT3 = '0; EX_PC = '0; EX_TARGET = '0;
        EX_PRED = 1'b0; BrRes = 1'b0;
        #2;
        for (int i = 0; i < 16; i++) check_pred("reset_pred", 32'(i) << 2, 1'b0);
        check("reset_ready", {31'b0, EX_READY}, 32'd1);
        check("reset_cnt", {16'h0, MISPRED_CNT}, 32'd0);
        check("reset_redirect", {31'b0, REDIRECT}, 32'd0);
        check("reset_flush", {31'b0, FLUSH}, 32'd0);
        check("reset_redirect_pc", REDIRECT_PC, 32'd0);
        @(negedge CLK) RST_N = 1'b1;
        tick();

        // BEQ taken, predicted not taken -> redirect to target.
        set_br(3'b000, 32'h100, 32'h140, 1'b0, 1'b0);
        exp_q.push_back('{pc: 32'h140, cnt: 16'd1});
        check_pred("pred_same_cycle", 32'h100, 1'b0);
        tick(); idle_ex();
        check("c1_redirect", {31'b0, REDIRECT}, 32'd1);
        check("c1_flush", {31'b0, FLUSH}, 32'd1);
        check("c1_ready", {31'b0, EX_READY}, 32'd0);
        check("c1_cnt", {16'h0, MISPRED_CNT}, 32'd1);
        check_pred("pred_after_update", 32'h100, 1'b1);
        tick();
        check("c2_redirect", {31'b0, REDIRECT}, 32'd0);
        check("c2_flush", {31'b0, FLUSH}, 32'd1);
        check("c2_ready", {31'b0, EX_READY}, 32'd0);
        tick();
        check("c3_flush", {31'b0, FLUSH}, 32'd0);
        check("c3_ready", {31'b0, EX_READY}, 32'd1);

        // BNE not taken at top of memory, predicted taken -> PC+4 wraps to 0.
        set_br(3'b001, 32'hFFFF_FFFC, 32'h500, 1'b1, 1'b0);
        exp_q.push_back('{pc: 32'h0, cnt: 16'd2});
        tick(); idle_ex();
        check("wrap_flush", {31'b0, FLUSH}, 32'd1);
        tick(); tick();
        check("wrap_ready_back", {31'b0, EX_READY}, 32'd1);

        // Three back-to-back correctly predicted taken BEQs.
        set_br(3'b000, 32'h100, 32'h140, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("b2b_ready", {31'b0, EX_READY}, 32'd1);
            tick();
        end
        idle_ex();
        check("b2b_redirect", {31'b0, REDIRECT}, 32'd0);
        check("b2b_flush", {31'b0, FLUSH}, 32'd0);
        check("b2b_cnt", {16'h0, MISPRED_CNT}, 32'd2);
        check_pred("b2b_pred", 32'h100, 1'b1);
        tick();
        check("b2b_no_late_redirect", {31'b0, REDIRECT}, 32'd0);

        // Not taken from saturated 11 -> 10, still predicts taken.
        set_br(3'b000, 32'h100, 32'h140, 1'b1, 1'b1);
        exp_q.push_back('{pc: 32'h104, cnt: 16'd3});
        tick(); idle_ex();
        check_pred("sat_pred", 32'h100, 1'b1);
        // Wrong-path branch presented during flush is dropped.
        set_br(3'b000, 32'h108, 32'h180, 1'b0, 1'b0);
        check("flush_ready", {31'b0, EX_READY}, 32'd0);
        tick();
        tick(); idle_ex();
        check("drop_ready", {31'b0, EX_READY}, 32'd1);
        check("drop_cnt", {16'h0, MISPRED_CNT}, 32'd3);
        check_pred("drop_pred", 32'h108, 1'b0);

        // Unsupported funct3 is ignored.
        set_br(3'b100, 32'h108, 32'h180, 1'b0, 1'b0);
        tick(); idle_ex();
        check("f3_flush", {31'b0, FLUSH}, 32'd0);
        check("f3_cnt", {16'h0, MISPRED_CNT}, 32'd3);
        check_pred("f3_pred", 32'h108, 1'b0);
        tick();
        check("f3_redirect", {31'b0, REDIRECT}, 32'd0);

        // Counter saturation.
        force dut.mispred_cnt_q = 16'hFFFF;
        tick();
        @(negedge CLK) release dut.mispred_cnt_q;
        tick();
        check("sat_cnt_loaded", {16'h0, MISPRED_CNT}, 32'h0000_FFFF);
        set_br(3'b000, 32'h10C, 32'h200, 1'b1, 1'b1);
        exp_q.push_back('{pc: 32'h110, cnt: 16'hFFFF});
        tick(); idle_ex();
        check("sat_cnt", {16'h0, MISPRED_CNT}, 32'h0000_FFFF);
        tick(); tick();
        check("sat_ready_back", {31'b0, EX_READY}, 32'd1);

        // Reset in the second flush cycle.
        set_br(3'b001, 32'h20, 32'h300, 1'b0, 1'b1);
        exp_q.push_back('{pc: 32'h300, cnt: 16'hFFFF});
        tick(); idle_ex();
        check("rst_c1_redirect", {31'b0, REDIRECT}, 32'd1);
        tick();
        check("rst_c2_flush", {31'b0, FLUSH}, 32'd1);
        RST_N = 1'b0;
        #1;
        check("rst_flush", {31'b0, FLUSH}, 32'd0);
        check("rst_redirect", {31'b0, REDIRECT}, 32'd0);
        check("rst_redirect_pc", REDIRECT_PC, 32'd0);
        check("rst_cnt", {16'h0, MISPRED_CNT}, 32'd0);
        check("rst_ready", {31'b0, EX_READY}, 32'd1);
        @(negedge CLK) RST_N = 1'b1;
        tick();
        check("post_rst_flush", {31'b0, FLUSH}, 32'd0);
        check("post_rst_redirect", {31'b0, REDIRECT}, 32'd0);
        check("post_rst_ready", {31'b0, EX_READY}, 32'd1);
        check_pred("post_rst_pred", 32'h100, 1'b0);
        tick();
        check("post_rst_flush2", {31'b0, FLUSH}, 32'd0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL redirects_seen: got %0d pending, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Back-end consumer of the branch comparator's `BrRes` (1 = operands not equal) in the execute stage. Resolves BEQ/BNE outcomes, checks them against the fetch-time prediction, and on a mispredict issues a registered PC redirect plus a multi-cycle pipeline flush. A 2-bit saturating branch history table (BHT) supplies the predictions to fetch.

## Interface
Parameters:
- `IDX_W`, 4: BHT index width; 2^IDX_W entries, indexed by PC[IDX_W+1:2].
- `FLUSH_CYC`, 2: number of cycles `FLUSH` is held per mispredict; legal range is 1 to 15.

Ports:
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RST_N`  in  1  asynchronous reset, active-low.
- `F_VALID`  in  1  fetch PC is valid.
- `F_PC`  in  32  fetch PC.
- `PRED_TAKEN`  out  1  prediction for `F_PC`; combinational.
- `EX_VALID`  in  1  execute-stage instruction valid.
- `EX_BR`  in  1  execute instruction is a conditional branch.
- `EX_FUNCT3`  in  3  branch type: 000 = BEQ, 001 = BNE.
- `EX_PC`  in  32  PC of the branch.
- `EX_TARGET`  in  32  PC+imm, computed in parallel by the execute stage.
- `EX_PRED`  in  1  prediction the branch was fetched with.
- `BrRes`  in  1  comparator result; 1 = RD1 != RD2.
- `EX_READY`  out  1  resolver can accept a branch this cycle.
- `REDIRECT`  out  1  one-cycle pulse: load `REDIRECT_PC` into the PC.
- `REDIRECT_PC`  out  32  corrected fetch address.
- `FLUSH`  out  1  squash IF/ID/EX wrong-path instructions.
- `MISPRED_CNT`  out  16  saturating mispredict counter.

## Operation
- A branch is accepted when `EX_VALID & EX_BR & EX_READY` and `EX_FUNCT3` is 000 or 001. Branches with any other funct3 are ignored: no BHT update, no redirect, no count.
- Actual outcome: BEQ taken = ~`BrRes`; BNE taken = `BrRes`.
- Mispredict = taken != `EX_PRED`.
- Correct path on mispredict:
  - `EX_TARGET` if taken.
  - `EX_PC` + 4 if not taken, wrapping modulo 2^32.
- FSM states: IDLE and FLUSHING, with a flush counter.
  - IDLE goes to FLUSHING on an accepted mispredict, and the counter loads `FLUSH_CYC`.
  - FLUSHING decrements the counter each cycle and returns to IDLE when it reaches 0.
  - A correctly predicted branch stays in IDLE.
- `EX_READY` = (state == IDLE). Branches presented while not ready are dropped; they are wrong-path instructions by construction.
- BHT entry updated on every accepted branch, including mispredicts:
  - Taken: increment, saturating at 11.
  - Not taken: decrement, saturating at 00.
- `PRED_TAKEN` = `F_VALID` & BHT[`F_PC` index][1].
- `MISPRED_CNT` increments on each accepted mispredict and saturates at 0xFFFF.

## Timing
- Reset values: all BHT entries 01 (weakly not taken), state IDLE, `REDIRECT` 0, `FLUSH` 0, `REDIRECT_PC` 0x00000000, `MISPRED_CNT` 0. Consequently `PRED_TAKEN` = 0 and `EX_READY` = 1.
- Resolution latency: 1 cycle.
  - On the edge that accepts a mispredict, the BHT, `REDIRECT_PC` and `MISPRED_CNT` update.
  - In the following cycle, `REDIRECT` = 1 and `FLUSH` = 1.
- `REDIRECT` is high exactly 1 cycle per mispredict.
- `FLUSH` is high exactly `FLUSH_CYC` consecutive cycles, starting with the `REDIRECT` cycle.
- `EX_READY` is low during those same `FLUSH_CYC` cycles, then returns high.
- `REDIRECT_PC` holds its value until the next mispredict.
- Same-cycle read and write of one BHT index: `PRED_TAKEN` shows the pre-update value; the new value is visible from the next cycle.
- Back-to-back correct branches in IDLE are accepted every cycle with no bubbles.
- `RST_N` asserted mid-flush: all outputs go to their reset values immediately, asynchronously. The FSM is in IDLE after release, with no residual pulse.
- All outputs except `PRED_TAKEN` and `EX_READY` are registered.

## Test plan
- Reset, then read every index with `F_VALID` = 1 → `PRED_TAKEN` = 0 for all 16 entries, `EX_READY` = 1, `MISPRED_CNT` = 0.
- BEQ at `EX_PC` = 0x100, `BrRes` = 0, `EX_PRED` = 0, `EX_TARGET` = 0x140 →
  - next cycle: `REDIRECT` pulse, `REDIRECT_PC` = 0x140.
  - `FLUSH` high for 2 cycles, `EX_READY` low for 2 cycles.
  - `MISPRED_CNT` = 1; BHT[0] = 10, so `F_PC` = 0x100 predicts taken.
- BNE at `EX_PC` = 0xFFFFFFFC, `BrRes` = 0, `EX_PRED` = 1 → `REDIRECT_PC` = 0x00000000 (wrap-around).
- Three correctly predicted BEQs on consecutive cycles → no `REDIRECT`, no `FLUSH`, `EX_READY` stays 1, BHT counters saturate as expected.
- Branch presented during `FLUSH` or with funct3 = 100 → ignored: no BHT change, no counter change.
- Force `MISPRED_CNT` to 0xFFFF and apply one more mispredict → count stays 0xFFFF.
- Assert `RST_N` low in the second `FLUSH` cycle → `FLUSH`, `REDIRECT` and `REDIRECT_PC` cleared immediately; `EX_READY` = 1 after release.
